// File: rtl/audio_pkg.sv
// Shared constants and elaboration helpers for the audio sample pacer.
package audio_pkg;

  localparam int DEF_CHANNELS     = 2;
  localparam int DEF_SAMPLE_WIDTH = 24;
  localparam int FRAME_W          = DEF_CHANNELS * DEF_SAMPLE_WIDTH;

  localparam int UNDERRUN_REPEAT = 0;
  localparam int UNDERRUN_MUTE   = 1;

  // round(sample_hz * 2^acc_width / clk_hz), all in 64-bit arithmetic
  function automatic logic [63:0] calc_phase_inc(input logic [63:0] clk_hz,
                                                 input logic [63:0] sample_hz,
                                                 input int          acc_width);
    return ((sample_hz << acc_width) + (clk_hz >> 1)) / clk_hz;
  endfunction

  function automatic bit phase_inc_ok(input logic [63:0] inc, input int acc_width);
    return (inc != 64'd0) && (inc < (64'd1 << (acc_width - 1)));
  endfunction

endpackage

// File: rtl/audio_frame_fifo.sv
// Synchronous frame FIFO with registered level/full/empty flags.
module audio_frame_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           push_i,
  input  logic [WIDTH-1:0]               wr_data_i,
  input  logic                           pop_i,
  output logic [WIDTH-1:0]               rd_data_o,
  output logic                           full_o,
  output logic                           empty_o,
  output logic [$clog2(DEPTH+1)-1:0]     level_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             full_q, full_d, empty_q, empty_d;
  logic             do_push, do_pop;

  assign do_push = push_i && !full_q;
  assign do_pop  = pop_i && !empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
    rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
    // extra pointer MSB separates "full" from "empty" when the indices match
    level_d  = LW'(wr_ptr_d - rd_ptr_d);
    empty_d  = (wr_ptr_d == rd_ptr_d);
    full_d   = (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

  assign rd_data_o = mem[rd_ptr_q[AW-1:0]];
  assign full_o    = full_q;
  assign empty_o   = empty_q;
  assign level_o   = level_q;

endmodule

// File: rtl/audio_sample_pacer.sv
// Fractional-rate audio sample timebase releasing buffered PCM frames one per tick.
module audio_sample_pacer
  import audio_pkg::*;
#(
  parameter int unsigned CLK_HZ        = 30000000,
  parameter int unsigned SAMPLE_HZ     = 48000,
  parameter int          CHANNELS      = DEF_CHANNELS,
  parameter int          SAMPLE_WIDTH  = DEF_SAMPLE_WIDTH,
  parameter int          FIFO_DEPTH    = 4,
  parameter int          ACC_WIDTH     = 32,
  parameter int          UNDERRUN_MODE = UNDERRUN_REPEAT
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 enable,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [CHANNELS*SAMPLE_WIDTH-1:0]     in_data,
  output logic                                 out_strobe,
  output logic [CHANNELS*SAMPLE_WIDTH-1:0]     out_data,
  output logic                                 out_clk,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]      level,
  output logic [15:0]                          underrun_count
);
  localparam int FW = CHANNELS * SAMPLE_WIDTH;
  localparam logic [63:0] INC64 = calc_phase_inc(64'(CLK_HZ), 64'(SAMPLE_HZ), ACC_WIDTH);
  localparam logic [ACC_WIDTH-1:0] INC = INC64[ACC_WIDTH-1:0];

  if (!phase_inc_ok(INC64, ACC_WIDTH)) begin : g_bad_inc
    $error("audio_sample_pacer: phase increment out of range");
  end
  if (CHANNELS < 1 || CHANNELS > 8) begin : g_bad_ch
    $error("audio_sample_pacer: CHANNELS must be 1..8");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("audio_sample_pacer: FIFO_DEPTH must be a power of 2, >= 2");
  end

  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [ACC_WIDTH:0]   sum;
  logic                 strobe_q, strobe_d, oclk_q, oclk_d;
  logic [FW-1:0]        out_data_q, out_data_d;
  logic [15:0]          ucnt_q, ucnt_d;
  logic                 tick, pop;
  logic [FW-1:0]        fifo_rd_data;
  logic                 fifo_full, fifo_empty;

  assign sum  = {1'b0, acc_q} + {1'b0, INC};
  assign tick = enable && sum[ACC_WIDTH];
  assign pop  = tick && !fifo_empty;

  always_comb begin
    acc_d      = '0;
    strobe_d   = 1'b0;
    oclk_d     = 1'b0;
    out_data_d = out_data_q;
    ucnt_d     = ucnt_q;
    if (enable) begin
      acc_d    = sum[ACC_WIDTH-1:0];
      strobe_d = sum[ACC_WIDTH];
      oclk_d   = sum[ACC_WIDTH-1];
    end
    if (pop) begin
      out_data_d = fifo_rd_data;
    end else if (tick) begin
      // a frame pushed on this same edge is not visible yet: still an underrun
      if (UNDERRUN_MODE == UNDERRUN_MUTE) out_data_d = '0;
      if (ucnt_q != 16'hFFFF) ucnt_d = ucnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q      <= '0;
      strobe_q   <= 1'b0;
      oclk_q     <= 1'b0;
      out_data_q <= '0;
      ucnt_q     <= '0;
    end else begin
      acc_q      <= acc_d;
      strobe_q   <= strobe_d;
      oclk_q     <= oclk_d;
      out_data_q <= out_data_d;
      ucnt_q     <= ucnt_d;
    end
  end

  audio_frame_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_i    (in_valid),
    .wr_data_i (in_data),
    .pop_i     (pop),
    .rd_data_o (fifo_rd_data),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .level_o   (level)
  );

  assign in_ready       = !fifo_full;
  assign out_strobe     = strobe_q;
  assign out_clk        = oclk_q;
  assign out_data       = out_data_q;
  assign underrun_count = ucnt_q;

endmodule

// File: tb/tb_audio_sample_pacer.sv
// Directed bench: repeat-mode and mute-mode pacers driven side by side.
module tb_audio_sample_pacer;

  localparam int FW = 48;

  logic          clk = 1'b0;
  logic          rst_n, enable, in_valid;
  logic [FW-1:0] in_data;

  logic          in_ready_r, out_strobe_r, out_clk_r;
  logic [FW-1:0] out_data_r;
  logic [2:0]    level_r;
  logic [15:0]   ucnt_r;
  logic          in_ready_m, out_strobe_m, out_clk_m;
  logic [FW-1:0] out_data_m;
  logic [2:0]    level_m;
  logic [15:0]   ucnt_m;

  int ncmp = 0, nfail = 0;
  logic [FW-1:0] frames [8];
  int push_cnt = 0, push_total = 0;

  always #5 clk = ~clk;

  audio_sample_pacer #(.CLK_HZ(1000), .SAMPLE_HZ(100), .CHANNELS(2), .SAMPLE_WIDTH(24),
    .FIFO_DEPTH(4), .ACC_WIDTH(16), .UNDERRUN_MODE(0)) dut_rep (
    .clk(clk), .rst_n(rst_n), .enable(enable), .in_valid(in_valid), .in_ready(in_ready_r),
    .in_data(in_data), .out_strobe(out_strobe_r), .out_data(out_data_r), .out_clk(out_clk_r),
    .level(level_r), .underrun_count(ucnt_r));

  audio_sample_pacer #(.CLK_HZ(1000), .SAMPLE_HZ(100), .CHANNELS(2), .SAMPLE_WIDTH(24),
    .FIFO_DEPTH(4), .ACC_WIDTH(16), .UNDERRUN_MODE(1)) dut_mute (
    .clk(clk), .rst_n(rst_n), .enable(enable), .in_valid(in_valid), .in_ready(in_ready_m),
    .in_data(in_data), .out_strobe(out_strobe_m), .out_data(out_data_m), .out_clk(out_clk_m),
    .level(level_m), .underrun_count(ucnt_m));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one clock; advances the producer when the frame offered before the edge was taken
  task automatic step();
    bit taken;
    taken = in_valid && in_ready_r;
    @(posedge clk); #1;
    if (taken) begin
      push_cnt++;
      if (push_cnt < push_total) in_data = frames[push_cnt];
      else in_valid = 1'b0;
    end
  endtask

  task automatic start_push(input int n);
    push_cnt = 0; push_total = n;
    in_data = frames[0]; in_valid = 1'b1;
  endtask

  task automatic wait_strobe(input string tag);
    int n;
    n = 0;
    do begin step(); n++; end while (!out_strobe_r && n < 40);
    chk({tag, "_strobe_r"}, 64'(out_strobe_r), 64'd1);
    chk({tag, "_strobe_m"}, 64'(out_strobe_m), 64'd1);
  endtask

  task automatic do_reset();
    in_valid = 1'b0; enable = 1'b0; push_total = 0; push_cnt = 0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int strobes, highs, toggles, gap_bad, last, n;
    logic prev_clk;
    rst_n = 1'b0; enable = 1'b0; in_valid = 1'b0; in_data = '0;

    // reset and idle
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_data", 64'(out_data_r), 64'd0);
    chk("rst_level", 64'(level_r), 64'd0);
    rst_n = 1'b1;
    strobes = 0; highs = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      strobes += int'(out_strobe_r) + int'(out_strobe_m);
      highs   += int'(out_clk_r) + int'(out_clk_m);
    end
    chk("idle_strobes", 64'(strobes), 64'd0);
    chk("idle_out_clk", 64'(highs), 64'd0);
    chk("idle_in_ready", 64'({in_ready_r, in_ready_m}), 64'h3);
    chk("idle_level", 64'({level_r, level_m}), 64'd0);
    chk("idle_out_data", 64'(out_data_r | out_data_m), 64'd0);
    chk("idle_ucnt", 64'({ucnt_r, ucnt_m}), 64'd0);

    // rate: 1000 enabled cycles with INC=6554
    enable = 1'b1;
    strobes = 0; toggles = 0; gap_bad = 0; last = -1; prev_clk = 1'b0;
    for (int i = 1; i <= 1000; i++) begin
      step();
      if (out_strobe_r) begin
        if (last >= 0 && (i - last - 1) != 9 && (i - last - 1) != 10) gap_bad++;
        last = i;
        strobes++;
      end
      if (out_clk_r != prev_clk) toggles++;
      prev_clk = out_clk_r;
    end
    enable = 1'b0;
    chk("rate_strobes", 64'(strobes), 64'd100);
    chk("rate_gaps", 64'(gap_bad), 64'd0);
    chk("rate_toggles", 64'(toggles), 64'd200);
    chk("rate_ucnt", 64'(ucnt_r), 64'd100);

    // backpressure
    do_reset();
    for (int k = 0; k < 6; k++) frames[k] = FW'(k + 1);
    start_push(6);
    repeat (4) step();
    chk("bp_in_ready", 64'({in_ready_r, in_ready_m}), 64'd0);
    chk("bp_level_full", 64'(level_r), 64'd4);
    repeat (3) step();
    chk("bp_level_hold", 64'(level_r), 64'd4);
    chk("bp_pushes_hold", 64'(push_cnt), 64'd4);
    enable = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      wait_strobe("bp");
      chk($sformatf("bp_frame%0d_r", k), 64'(out_data_r), 64'(k));
      chk($sformatf("bp_frame%0d_m", k), 64'(out_data_m), 64'(k));
      if (k == 4) begin
        chk("bp_pushes_all", 64'(push_cnt), 64'd6);
        chk("bp_level_after4", 64'(level_r), 64'd2);
      end
    end
    wait_strobe("bp_ur");
    chk("bp_ur_repeat", 64'(out_data_r), 64'd6);
    chk("bp_ur_mute", 64'(out_data_m), 64'd0);
    chk("bp_ur_cnt", 64'({ucnt_r, ucnt_m}), {32'd0, 16'd1, 16'd1});

    // underrun repeat / mute
    do_reset();
    frames[0] = 48'hABCDEF_123456;
    start_push(1);
    step();
    chk("ur_level", 64'(level_r), 64'd1);
    enable = 1'b1;
    wait_strobe("ur1");
    chk("ur1_data_r", 64'(out_data_r), 64'hABCDEF_123456);
    chk("ur1_data_m", 64'(out_data_m), 64'hABCDEF_123456);
    wait_strobe("ur2");
    chk("ur2_data_m", 64'(out_data_m), 64'd0);
    wait_strobe("ur3");
    chk("ur3_data_r", 64'(out_data_r), 64'hABCDEF_123456);
    chk("ur3_data_m", 64'(out_data_m), 64'd0);
    chk("ur3_ucnt", 64'({ucnt_r, ucnt_m}), {32'd0, 16'd2, 16'd2});

    // push coinciding with the wrapping add on an empty FIFO
    do_reset();
    enable = 1'b1;
    strobes = 0;
    for (int i = 0; i < 9; i++) begin step(); strobes += int'(out_strobe_r); end
    chk("co_no_early_strobe", 64'(strobes), 64'd0);
    frames[0] = 48'h111111_222222;
    start_push(1);
    step();
    chk("co_strobe", 64'(out_strobe_r), 64'd1);
    chk("co_ucnt", 64'(ucnt_r), 64'd1);
    chk("co_level", 64'(level_r), 64'd1);
    chk("co_data_hold", 64'(out_data_r), 64'd0);
    wait_strobe("co_next");
    chk("co_next_data_r", 64'(out_data_r), 64'h111111_222222);
    chk("co_next_data_m", 64'(out_data_m), 64'h111111_222222);
    chk("co_next_level", 64'(level_r), 64'd0);
    chk("co_next_ucnt", 64'(ucnt_r), 64'd1);

    // async reset mid-stream
    enable = 1'b0;
    frames[0] = 48'hA1; frames[1] = 48'hA2; frames[2] = 48'hA3;
    start_push(3);
    repeat (3) step();
    chk("ar_level3", 64'(level_r), 64'd3);
    enable = 1'b1;
    repeat (6) step();
    chk("ar_clk_high", 64'(out_clk_r), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_level", 64'({level_r, level_m}), 64'd0);
    chk("ar_out_clk", 64'({out_clk_r, out_clk_m}), 64'd0);
    chk("ar_out_data", 64'(out_data_r), 64'd0);
    chk("ar_ucnt", 64'(ucnt_r), 64'd0);
    chk("ar_strobe", 64'(out_strobe_r), 64'd0);
    rst_n = 1'b1;
    n = 0;
    do begin step(); n++; end while (!out_strobe_r && n < 40);
    chk("ar_first_strobe_cycles", 64'(n), 64'd10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
